// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, transmitter state encoding and
// a width-generic parity helper that the receiver can reuse.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    // Widest supported data word; narrower words are zero-extended, which leaves the XOR unchanged.
    localparam int MAX_DATA_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_param_baud_tick.sv
// Bit-period counter for the UART transmitter: flags the last clock of every
// serial bit and restarts from zero whenever clear is asserted.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional
// even/odd parity and one or two stop bits, with zero-gap back-to-back frames.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              has_par_q, has_par_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              frame_done_q, frame_done_d;

    logic accept;
    logic bit_end;
    logic last_stop;
    logic baud_clear;

    assign accept     = tx_valid & tx_ready;
    assign last_stop  = (bit_idx_q == {{(IDX_W-1){1'b0}}, stop2_q});
    assign baud_clear = accept || (state_q == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            has_par_q    <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            has_par_q    <= has_par_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        has_par_d    = has_par_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = has_par_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept is only possible in IDLE or the final stop clock, so it overrides either path.
        if (accept) begin
            state_d   = ST_START;
            shift_d   = tx_data;
            bit_idx_d = '0;
            has_par_d = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit_d = parity_bit(MAX_DATA_W'(tx_data), parity_mode == PAR_ODD);
            stop2_d   = stop2;
        end
    end

    always_comb begin
        tx_ready   = 1'b0;
        txd        = 1'b1;
        busy       = (state_q != ST_IDLE);
        frame_done = frame_done_q;

        case (state_q)
            ST_IDLE: begin
                tx_ready = ~rst;
            end
            ST_START: begin
                txd = 1'b0;
            end
            ST_DATA: begin
                txd = shift_q[0];
            end
            ST_PARITY: begin
                txd = par_bit_q;
            end
            ST_STOP: begin
                tx_ready = ~rst & bit_end & last_stop;
            end
            default: begin
                txd = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: directed and randomised frames compared
// cycle by cycle against a frame-level model of the serial line.
module tb_uart_tx_param;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic              txd;
    logic              busy;
    logic              frame_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [1:0]        m;
        logic              s2;
    } frame_t;

    frame_t burst[$];

    uart_tx_param #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic bit hasPar(input frame_t f);
        return (f.m == 2'b01) || (f.m == 2'b10);
    endfunction

    function automatic int frameLen(input frame_t f);
        return (1 + DATA_W + (hasPar(f) ? 1 : 0) + (f.s2 ? 2 : 1)) * CPB;
    endfunction

    // Expected line level during bit period p of frame f.
    function automatic logic expBit(input frame_t f, input int p);
        if (p == 0) return 1'b0;
        if (p <= DATA_W) return f.d[p-1];
        if (hasPar(f) && p == DATA_W + 1)
            return (($countones(f.d) % 2) == 1) ^ (f.m == 2'b10);
        return 1'b1;
    endfunction

    task automatic applyStimulus(input frame_t f, input logic v);
        tx_data     = f.d;
        parity_mode = f.m;
        stop2       = f.s2;
        tx_valid    = v;
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at the negedge of frame cycle 0; returns at the negedge one cycle past the frame.
    task automatic checkFrame(input frame_t f, input bit chained_in, input bit scramble, input int fid);
        int len;
        len = frameLen(f);
        for (int k = 0; k < len; k++) begin
            checkOutput($sformatf("f%0d_txd_c%0d", fid, k), txd, expBit(f, k / CPB));
            checkOutput($sformatf("f%0d_busy_c%0d", fid, k), busy, 1'b1);
            checkOutput($sformatf("f%0d_ready_c%0d", fid, k), tx_ready, (k == len - 1));
            checkOutput($sformatf("f%0d_done_c%0d", fid, k), frame_done, (k == 0) && chained_in);
            if (scramble) begin
                tx_data     = DATA_W'($urandom);
                parity_mode = 2'($urandom);
                stop2       = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic runBurst(input int tag);
        checkOutput($sformatf("b%0d_idle_ready", tag), tx_ready, 1'b1);
        checkOutput($sformatf("b%0d_idle_busy", tag), busy, 1'b0);
        applyStimulus(burst[0], 1'b1);
        @(negedge clk);
        for (int i = 0; i < burst.size(); i++) begin
            if (i + 1 < burst.size()) applyStimulus(burst[i+1], 1'b1);
            else tx_valid = 1'b0;
            checkFrame(burst[i], i > 0, i + 1 == burst.size(), tag * 10 + i);
        end
        checkOutput($sformatf("b%0d_end_done", tag), frame_done, 1'b1);
        checkOutput($sformatf("b%0d_end_busy", tag), busy, 1'b0);
        checkOutput($sformatf("b%0d_end_txd", tag), txd, 1'b1);
        checkOutput($sformatf("b%0d_end_ready", tag), tx_ready, 1'b1);
        @(negedge clk);
        checkOutput($sformatf("b%0d_done_clear", tag), frame_done, 1'b0);
    endtask

    initial begin
        frame_t f;
        int n;

        rst = 1'b1;
        applyStimulus('{d: 8'h00, m: 2'b00, s2: 1'b0}, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_txd", txd, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", frame_done, 1'b0);
        checkOutput("rst_ready", tx_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        burst.delete(); burst.push_back('{d: 8'h55, m: 2'b00, s2: 1'b0}); runBurst(1);
        burst.delete(); burst.push_back('{d: 8'h07, m: 2'b01, s2: 1'b0}); runBurst(2);
        burst.delete(); burst.push_back('{d: 8'h07, m: 2'b10, s2: 1'b0}); runBurst(3);
        burst.delete(); burst.push_back('{d: 8'h00, m: 2'b10, s2: 1'b1}); runBurst(4);
        burst.delete();
        burst.push_back('{d: 8'hA3, m: 2'b00, s2: 1'b0});
        burst.push_back('{d: 8'h3C, m: 2'b00, s2: 1'b0});
        runBurst(5);
        burst.delete(); burst.push_back('{d: 8'hC9, m: 2'b11, s2: 1'b1}); runBurst(6);

        // Abandon a frame with reset during data bit 3 (cycles 16..19).
        f = '{d: 8'hA5, m: 2'b00, s2: 1'b0};
        applyStimulus(f, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            checkOutput($sformatf("rf_txd_c%0d", k), txd, expBit(f, k / CPB));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_txd", txd, 1'b1);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", frame_done, 1'b0);
        checkOutput("midrst_ready", tx_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_ready", tx_ready, 1'b1);
        for (int k = 0; k < 30; k++) begin
            checkOutput($sformatf("postrst_txd_c%0d", k), txd, 1'b1);
            checkOutput($sformatf("postrst_done_c%0d", k), frame_done, 1'b0);
            @(negedge clk);
        end

        for (int b = 0; b < 20; b++) begin
            burst.delete();
            n = 1 + int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                f.d  = DATA_W'($urandom);
                f.m  = 2'($urandom_range(0, 3));
                f.s2 = 1'($urandom_range(0, 1));
                burst.push_back(f);
            end
            runBurst(100 + b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
